spi2ws2811: RTL and testbench
=============================

Name: spi2ws2811

Overview:
- Tiny Tapeout user block: SPI slave (mode 0) that receives GRB colour bytes and re-serialises them as a WS2811/WS2812 single-wire 800 kHz NRZ stream.
- Bytes are buffered in a small FIFO, emitted MSB first, and followed by a latch/reset low period after chip-select deasserts.
- Sits directly behind the TT harness pins (ui/uo/uio).

Parameters:
- T0H, 20, clock cycles high for a 0 bit (0.4 us @ 50 MHz)
- T1H, 40, clock cycles high for a 1 bit (0.8 us)
- TBIT, 62, total clock cycles per bit (1.24 us)
- TRESET, 2600, clock cycles low for latch (52 us)
- FIFO_DEPTH, 4, byte FIFO entries (power of two)

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1). The harness port name is kept; polarity is active-high.
- ena  in  1  design selected; ignored (no gating)
- ui_in  in  8  [0]=SCK, [1]=MOSI, [2]=CS_N (active low), [7:3] unused
- uo_out  out  8  [0]=WS_OUT, [1]=BUSY, [2]=OVERFLOW, [3]=FIFO_EMPTY, [7:4]=0
- uio_in  in  8  unused
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all inputs)

Behaviour:
- Reset (async, active-high):
  - WS_OUT=0, BUSY=0, OVERFLOW=0, FIFO_EMPTY=1.
  - FIFO empty; shift register and bit counter cleared; serializer IDLE.
- Input synchronisation and edge detect:
  - SCK, MOSI and CS_N each pass through a 2-flop synchroniser.
  - SCK rising edge is detected on synchronised samples.
  - SCK must be at most clk/8.
- SPI receive (mode 0, MSB first):
  - While CS_N=0, each SCK rising edge shifts MOSI into the shift register and increments a 3-bit count.
  - On the 8th bit, the byte is pushed to the FIFO and the count wraps to 0.
  - CS_N=1 clears the bit count and discards any partial byte.
  - CS_N falling edge clears OVERFLOW.
- FIFO:
  - Push while full: byte dropped, OVERFLOW set (sticky).
  - Simultaneous push and pop is allowed; occupancy is unchanged.
  - FIFO_EMPTY = (count==0).
- Serializer FSM, states IDLE, LOAD, HIGH, LOW, RESET:
  - IDLE: if FIFO not empty → LOAD.
  - LOAD: pop byte, bit index=7 → HIGH.
  - HIGH: WS_OUT=1 for T0H or T1H cycles depending on the current bit → LOW.
  - LOW: WS_OUT=0 until TBIT total cycles elapse for that bit. If bits remain, decrement index → HIGH. Else, if FIFO not empty → LOAD (no gap beyond a 1-cycle LOAD; the LOW phase absorbs it, so bit period stays TBIT). Else → RESET.
  - RESET: WS_OUT=0 for TRESET cycles. A new byte arriving mid-RESET restarts transmission immediately (→ LOAD) without completing the latch. On completion → IDLE.
  - BUSY=1 in any state except IDLE.
- Latency: the first WS_OUT rise occurs no more than 5 clk cycles after the 8th SCK rising edge reaches the pin.
- Reset mid-frame: outputs go to reset values immediately; the partial frame is abandoned.
- ena low has no effect.
- All unused outputs are driven 0.

Test Plan:
- Reset: assert rst_n=1 for 10 cycles, release → uo_out=8'b0000_1000, uio_oe=0, uio_out=0.
- Single byte 0xA5 via SPI (SCK=clk/10, CS_N low, 8 bits, CS_N high):
  - WS_OUT shows 8 bits; high widths 40,20,40,20,20,40,20,40 cycles; each bit period 62 cycles.
  - Then low ≥2600 cycles, BUSY falls to 0.
- Three bytes 0xFF,0x00,0x81 in one CS window → 24 contiguous bits, no extra gap between bytes; one latch period after the last bit.
- Overflow: send 6 bytes back-to-back at SCK=clk/8 → OVERFLOW=1 after the drop. Only bytes that fit are output, in order. Next CS_N falling edge → OVERFLOW=0.
- Partial byte: 5 SCK edges then CS_N high → no WS_OUT activity, FIFO_EMPTY stays 1.
- Async reset during byte transmission → WS_OUT=0 and BUSY=0 before the next clk edge. Subsequent byte 0x01 transmits correctly.

Source files
------------

// File: rtl/spi2ws2811.sv
// SPI mode-0 slave feeding a small byte FIFO that is re-serialised as a
// WS2811/WS2812 800 kHz NRZ stream, wrapped in the Tiny Tapeout pin harness.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | line low, waiting for a byte in the FIFO
// LOAD    | pop next byte, start at bit 7
// HIGH    | WS_OUT high for T0H/T1H of the current bit
// LOW     | WS_OUT low for the rest of the TBIT bit period
// RESET   | WS_OUT low for the TRESET latch period
module spi2ws2811 #(
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 62,
  parameter int TRESET     = 2600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_RESET = 3'd4;

  // One down-counter spans a whole bit period; HIGH ends at a compare value.
  localparam logic [11:0] TBIT_LAST = 12'(TBIT - 1);
  localparam logic [11:0] H0_END    = 12'(TBIT - T0H);
  localparam logic [11:0] H1_END    = 12'(TBIT - T1H);
  localparam logic [11:0] RST_LAST  = 12'(TRESET - 1);
  localparam logic [11:0] TMR_ONE   = 12'd1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic       unused_in;
  assign unused_in = &{1'b0, ena, uio_in, ui_in[7:3]};

  logic [1:0] sck_sy, mosi_sy, cs_sy;
  logic       sck_d, cs_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sck_sy  <= 2'b00;
      mosi_sy <= 2'b00;
      cs_sy   <= 2'b11;
      sck_d   <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sck_sy  <= {sck_sy[0], ui_in[0]};
      mosi_sy <= {mosi_sy[0], ui_in[1]};
      cs_sy   <= {cs_sy[0], ui_in[2]};
      sck_d   <= sck_sy[1];
      cs_d    <= cs_sy[1];
    end
  end

  logic sck_rise, cs_fall, cs_act;
  assign sck_rise = sck_sy[1] & ~sck_d;
  assign cs_fall  = cs_d & ~cs_sy[1];
  assign cs_act   = ~cs_sy[1];

  logic [6:0] rx_sr;
  logic [2:0] rx_cnt;
  logic       push;
  logic [7:0] push_data;

  // The 8th bit goes straight into the FIFO, so only 7 bits are held.
  assign push      = cs_act & sck_rise & (rx_cnt == 3'd7);
  assign push_data = {rx_sr, mosi_sy[1]};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (!cs_act) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (sck_rise) begin
      rx_sr  <= {rx_sr[5:0], mosi_sy[1]};
      rx_cnt <= rx_cnt + 3'd1;
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, wr_en, pop, overflow;
  logic [2:0]    state;

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign wr_en      = push & ~fifo_full;
  assign pop        = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                  overflow <= 1'b0;
    else if (cs_fall)           overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
  end

  logic [7:0]  tx_byte;
  logic [2:0]  bit_idx;
  logic [11:0] tmr;
  logic [11:0] high_end;

  assign high_end = tx_byte[bit_idx] ? H1_END : H0_END;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= S_IDLE;
      tx_byte <= '0;
      bit_idx <= '0;
      tmr     <= '0;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) state <= S_LOAD;
        S_LOAD: begin
          tx_byte <= mem[rd_ptr];
          bit_idx <= 3'd7;
          tmr     <= TBIT_LAST;
          state   <= S_HIGH;
        end
        S_HIGH: begin
          tmr <= tmr - TMR_ONE;
          if (tmr == high_end) state <= S_LOW;
        end
        S_LOW: begin
          tmr <= tmr - TMR_ONE;
          if (bit_idx != 3'd0) begin
            if (tmr == '0) begin
              bit_idx <= bit_idx - 3'd1;
              tmr     <= TBIT_LAST;
              state   <= S_HIGH;
            end
          end else if (tmr == TMR_ONE && !fifo_empty) begin
            // Leave one cycle early so LOAD fits inside this bit period.
            state <= S_LOAD;
          end else if (tmr == '0) begin
            if (!fifo_empty) begin
              state <= S_LOAD;
            end else begin
              tmr   <= RST_LAST;
              state <= S_RESET;
            end
          end
        end
        S_RESET: begin
          tmr <= tmr - TMR_ONE;
          if (!fifo_empty)     state <= S_LOAD;
          else if (tmr == '0)  state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic ws_out, busy;
  assign ws_out = (state == S_HIGH);
  assign busy   = (state != S_IDLE);

  assign uo_out  = {4'b0000, fifo_empty, overflow, busy, ws_out};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_spi2ws2811.sv
// Bench for spi2ws2811: SPI frames in, WS2811 pulse train measured and
// compared against widths/periods derived from the byte values.
`timescale 1ns/1ps

module tb_spi2ws2811;

  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 62;
  localparam int TRESET = 2600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  assign ui_in  = {5'b00000, cs_n, mosi, sck};
  assign uio_in = 8'h00;

  spi2ws2811 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #10 clk = ~clk;

  logic ws, busy, ovf, fe;
  assign ws   = uo_out[0];
  assign busy = uo_out[1];
  assign ovf  = uo_out[2];
  assign fe   = uo_out[3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         rise_q[$];
  int         fall_q[$];
  int         busy_fall_t = -1;
  int         sck8_t = -1;
  bit         ws_prev = 0, busy_prev = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      ws_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (ws && !ws_prev) rise_q.push_back(cyc);
      if (!ws && ws_prev) fall_q.push_back(cyc);
      if (!busy && busy_prev) busy_fall_t = cyc;
      ws_prev   = ws;
      busy_prev = busy;
    end
  end

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, limit %0d", name, act, req);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    busy_fall_t = -1;
    sck8_t = -1;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, input int half, input bit rec);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      if (rec && i == 7) sck8_t = cyc;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int half, input int nbits);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    foreach (tx_q[j]) spi_byte(tx_q[j], nbits, half, j == 0);
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(busy == 1'b0 && fe == 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < limit, n, limit);
    repeat (5) @(negedge clk);
  endtask

  // Expected pulse train: MSB first, T1H for a 1 and T0H for a 0, every
  // bit TBIT apart, then a latch low of at least TRESET before BUSY drops.
  task automatic check_frame(input string tag);
    int nb = exp_q.size() * 8;
    cmp({tag, ".rises"}, rise_q.size(), nb);
    cmp({tag, ".falls"}, fall_q.size(), nb);
    if (rise_q.size() == nb && fall_q.size() == nb && nb > 0) begin
      for (int k = 0; k < nb; k++) begin
        logic [7:0] b;
        b = exp_q[k/8];
        cmp({tag, ".width"}, fall_q[k] - rise_q[k], b[7-(k%8)] ? T1H : T0H);
        if (k > 0) cmp({tag, ".period"}, rise_q[k] - rise_q[k-1], TBIT);
      end
      chk({tag, ".latency"}, (rise_q[0] - sck8_t) <= 5 && (rise_q[0] - sck8_t) >= 1,
          rise_q[0] - sck8_t, 5);
      chk({tag, ".latch"}, busy_fall_t >= 0 && (busy_fall_t - fall_q[nb-1]) >= TRESET,
          busy_fall_t - fall_q[nb-1], TRESET);
    end
    cmp({tag, ".ws_end"}, int'(ws), 0);
    cmp({tag, ".empty_end"}, int'(fe), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         half;
    int         exp_pulses;
    int         exp_empty;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #(1_900_000);
    $display("FAIL watchdog: got %0d cycles, limit %0d", cyc, 95000);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8, 5, 8, 1};
    vecs[1] = '{8'h3C, 5, 5, 0, 1};
    vecs[2] = '{8'h01, 8, 4, 8, 1};
    vecs[3] = '{8'h5A, 3, 4, 0, 1};
    vecs[4] = '{8'hC3, 8, 6, 8, 1};

    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cmp("reset_held.uo_out", int'(uo_out), 8'h08);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset.uo_out", int'(uo_out), 8'h08);
    cmp("reset.uio_oe", int'(uio_oe), 0);
    cmp("reset.uio_out", int'(uio_out), 0);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      tx_q.delete();
      exp_q.delete();
      tx_q.push_back(vecs[v].data);
      if (vecs[v].nbits == 8) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].half, vecs[v].nbits);
      wait_idle(8000);
      cmp("vec.pulses", rise_q.size(), vecs[v].exp_pulses);
      cmp("vec.empty", int'(fe), vecs[v].exp_empty);
      check_frame("vec");
    end

    clear_mon();
    tx_q = '{8'hFF, 8'h00, 8'h81};
    exp_q = tx_q;
    send_frame(5, 8);
    wait_idle(8000);
    check_frame("three");

    clear_mon();
    tx_q.delete();
    for (int j = 0; j < 6; j++) tx_q.push_back(8'($urandom));
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 5; j++) spi_byte(tx_q[j], 8, 4, j == 0);
    repeat (4) @(negedge clk);
    cmp("ovf.before_drop", int'(ovf), 0);
    spi_byte(tx_q[5], 8, 4, 1'b0);
    repeat (4) @(negedge clk);
    cmp("ovf.after_drop", int'(ovf), 1);
    cs_n = 1'b1;
    exp_q.delete();
    for (int j = 0; j < 5; j++) exp_q.push_back(tx_q[j]);
    wait_idle(9000);
    check_frame("ovf");
    cmp("ovf.sticky", int'(ovf), 1);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    cmp("ovf.cleared", int'(ovf), 0);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      int n;
      int half;
      clear_mon();
      tx_q.delete();
      n = int'($urandom_range(1, 3));
      half = int'($urandom_range(4, 6));
      ena = 1'($urandom);
      for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
      exp_q = tx_q;
      send_frame(half, 8);
      wait_idle(8000);
      check_frame("rand");
    end
    ena = 1'b1;

    clear_mon();
    tx_q = '{8'hA5};
    send_frame(5, 8);
    begin
      int n = 0;
      while (rise_q.size() < 3 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("midreset.wait", n < 2000, n, 2000);
    end
    repeat (7) @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    cmp("midreset.ws", int'(ws), 0);
    cmp("midreset.busy", int'(busy), 0);
    cmp("midreset.empty", int'(fe), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    tx_q = '{8'h01};
    exp_q = tx_q;
    send_frame(5, 8);
    wait_idle(8000);
    check_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
